cache_rd_req_issuer: RTL and testbench

//  Upstream feeder for the LRU cache front-end AXI4 read slave (64-bit data, single-beat reads).

---
 rtl/cache_rd_req_issuer_if.sv | 59 +++++
 rtl/cache_rd_req_issuer.sv | 140 ++++++++++++++
 tb/tb_cache_rd_req_issuer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_rd_req_issuer_if.sv
// Bus bundle for the cache read-request issuer. It carries the lookup request stream,
// the AXI4 AR/R channels toward the cache front-end, and the tagged response stream.
interface cache_rd_req_issuer_if #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 16
);
    // Lookup request stream from the packet-processing logic
    logic                  req_tvalid;
    logic                  req_tready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [TAG_WIDTH-1:0]  req_tag;

    // AXI4 read address channel
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arid;

    // AXI4 read data channel
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;

    // Tagged response stream back to the requester
    logic                  resp_tvalid;
    logic                  resp_tready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [TAG_WIDTH-1:0]  resp_tag;
    logic                  resp_err;

    // The issuer side: AXI master toward the cache, sink of requests, source of responses
    modport master (
        input  req_tvalid, req_addr, req_tag,
        output req_tready,
        output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid,
        input  m_axi_arready,
        input  m_axi_rvalid, m_axi_rdata, m_axi_rresp,
        output m_axi_rready,
        output resp_tvalid, resp_data, resp_tag, resp_err,
        input  resp_tready
    );

    // The surrounding system: requester, cache front-end and response consumer
    modport slave (
        output req_tvalid, req_addr, req_tag,
        input  req_tready,
        input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid,
        output m_axi_arready,
        output m_axi_rvalid, m_axi_rdata, m_axi_rresp,
        input  m_axi_rready,
        input  resp_tvalid, resp_data, resp_tag, resp_err,
        output resp_tready
    );
endinterface

// File: rtl/cache_rd_req_issuer.sv
// Cache read-request issuer.
// Turns {addr, tag} lookup requests into single-beat AXI4 reads toward the LRU cache
// front-end, bounds the number of reads in flight, and pairs each in-order R beat with
// the tag of the request that produced it. ARID is fixed at 0, so responses are in order.
module cache_rd_req_issuer #(
    parameter int ADDR_WIDTH      = 48,
    parameter int DATA_WIDTH      = 64,
    parameter int TAG_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    cache_rd_req_issuer_if.master              bus,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               err_unexpected_r
);

    localparam int PTR_W    = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W    = PTR_W + 1;
    localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);

    // Clears the byte-offset bits so every read is aligned to one data beat
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << ADDR_LSB;
    localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(MAX_OUTSTANDING);

    // AR output register
    logic                  arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;

    // In-flight counter and tag FIFO pointers
    logic [CNT_W-1:0]      count_q,   count_d;
    logic [PTR_W-1:0]      wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,  rd_ptr_d;

    // Sticky flag for R beats that arrive with nothing in flight
    logic                  err_q,     err_d;

    // Tag storage; one slot per read that may be in flight
    logic [TAG_WIDTH-1:0]  tag_mem [MAX_OUTSTANDING];

    logic                  have_outstanding;
    logic                  ar_slot_free;
    logic                  fifo_room;
    logic                  accept;
    logic                  deliver;

    // Fixed AR attributes: single beat, full-width, incrementing, single ID
    assign bus.m_axi_arlen   = 8'd0;
    assign bus.m_axi_arsize  = 3'(ADDR_LSB);
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arid    = 1'b0;

    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_araddr  = araddr_q;
    assign outstanding       = count_q;
    assign err_unexpected_r  = err_q;

    // Handshake decode; the full check uses the registered count, so a delivery
    // at full only re-opens the request port on the following cycle
    always_comb begin
        have_outstanding = (count_q != '0);
        ar_slot_free     = ~arvalid_q | bus.m_axi_arready;
        fifo_room        = (count_q < CNT_MAX);
        bus.req_tready   = ar_slot_free & fifo_room & ~rst;
        accept           = bus.req_tvalid & bus.req_tready;

        bus.resp_tvalid  = 1'b0;
        bus.m_axi_rready = 1'b1;
        if (have_outstanding) begin
            bus.resp_tvalid  = bus.m_axi_rvalid;
            bus.m_axi_rready = bus.resp_tready;
        end

        deliver       = bus.m_axi_rvalid & bus.m_axi_rready & have_outstanding;
        bus.resp_data = bus.m_axi_rdata;
        bus.resp_err  = bus.m_axi_rresp[1];
        bus.resp_tag  = tag_mem[rd_ptr_q];
    end

    // Next-state for the AR register, the in-flight counter, the FIFO pointers and the error flag
    always_comb begin
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        err_d     = err_q;

        if (accept) begin
            arvalid_d = 1'b1;
            araddr_d  = bus.req_addr & ADDR_MASK;
        end else if (bus.m_axi_arready) begin
            arvalid_d = 1'b0;
        end

        case ({accept, deliver})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (deliver) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (bus.m_axi_rvalid && !have_outstanding) begin
            err_d = 1'b1;
        end
    end

    // State registers; reset discards everything that was in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            err_q     <= err_d;
        end
    end

    // Tag FIFO storage; the tag is captured in the same cycle its request is accepted
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[wr_ptr_q] <= bus.req_tag;
        end
    end

endmodule

// File: tb/tb_cache_rd_req_issuer.sv
// Directed self-checking bench for cache_rd_req_issuer.
// Inputs change 1 ns after the rising edge; handshakes are recorded on the falling edge.
`timescale 1ns/1ps
module tb_cache_rd_req_issuer;

    localparam int ADDR_WIDTH      = 48;
    localparam int DATA_WIDTH      = 64;
    localparam int TAG_WIDTH       = 16;
    localparam int MAX_OUTSTANDING = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] outstanding;
    logic       errUnexpectedR;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Handshake bookkeeping filled in by the cycle task
    int  acceptCount = 0;
    int  arCount     = 0;
    bit  sawAccept   = 0;
    bit  sawDelivery = 0;
    bit  autoResp    = 0;
    logic [ADDR_WIDTH-1:0] arQ[$];
    logic [TAG_WIDTH-1:0]  respTags[$];
    logic [DATA_WIDTH-1:0] respData[$];

    int idx;

    cache_rd_req_issuer_if #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
    ) bus ();

    cache_rd_req_issuer #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .DATA_WIDTH      (DATA_WIDTH),
        .TAG_WIDTH       (TAG_WIDTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .outstanding      (outstanding),
        .err_unexpected_r (errUnexpectedR)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value and tally the result
    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, observed, expected);
        end
    endtask

    // Drive the lookup request port
    task automatic applyStimulus(input logic valid, input logic [ADDR_WIDTH-1:0] addr, input logic [TAG_WIDTH-1:0] tag);
        bus.req_tvalid = valid;
        bus.req_addr   = addr;
        bus.req_tag    = tag;
    endtask

    // Cache read data derived from the (aligned) address the cache was asked for
    function automatic logic [DATA_WIDTH-1:0] dataFor(input logic [ADDR_WIDTH-1:0] a);
        return {16'hC0DE, a};
    endfunction

    // Advance one clock, recording handshakes on the falling edge
    task automatic cycle();
        @(negedge clk);
        sawAccept   = bus.req_tvalid && bus.req_tready;
        sawDelivery = bus.resp_tvalid && bus.resp_tready;
        if (sawAccept) acceptCount++;
        if (autoResp && bus.m_axi_rvalid && bus.m_axi_rready && arQ.size() > 0) void'(arQ.pop_front());
        if (bus.m_axi_arvalid && bus.m_axi_arready) begin
            arCount++;
            arQ.push_back(bus.m_axi_araddr);
        end
        if (sawDelivery) begin
            respTags.push_back(bus.resp_tag);
            respData.push_back(bus.resp_data);
        end
        @(posedge clk);
        #1;
        if (autoResp) begin
            bus.m_axi_rvalid = (arQ.size() > 0);
            bus.m_axi_rdata  = (arQ.size() > 0) ? dataFor(arQ[0]) : '0;
        end
    endtask

    // Return n R beats back to back, expecting consecutive tags; beat 1 carries SLVERR
    task automatic drain(input string name, input logic [TAG_WIDTH-1:0] firstTag, input int n);
        bus.resp_tready = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.m_axi_rvalid = 1'b1;
            bus.m_axi_rdata  = 64'hA5A5_0000_0000_0000 | 64'(i);
            bus.m_axi_rresp  = (i == 1) ? 2'b10 : 2'b00;
            #1;
            checkOutput({name, "_tag"}, 64'(bus.resp_tag), 64'(firstTag) + 64'(i));
            checkOutput({name, "_err"}, 64'(bus.resp_err), (i == 1) ? 64'd1 : 64'd0);
            cycle();
        end
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rresp  = 2'b00;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, '0, '0);
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rresp   = 2'b00;
        bus.resp_tready   = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) cycle();
        rst = 1'b0;
        #1;
        checkOutput("rst_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
        checkOutput("rst_araddr", 64'(bus.m_axi_araddr), 64'd0);
        checkOutput("rst_outstanding", 64'(outstanding), 64'd0);
        checkOutput("rst_err", 64'(errUnexpectedR), 64'd0);
        checkOutput("rst_req_tready", 64'(bus.req_tready), 64'd1);

        // ---------------- 1: single request ----------------
        $display("[TB] test 1: single request");
        bus.m_axi_arready = 1'b1;
        applyStimulus(1'b1, 48'h1234_5678_9ABF, 16'h00A5);
        #1;
        checkOutput("t1_req_tready", 64'(bus.req_tready), 64'd1);
        cycle();
        applyStimulus(1'b0, '0, '0);
        checkOutput("t1_arvalid", 64'(bus.m_axi_arvalid), 64'd1);
        checkOutput("t1_araddr", 64'(bus.m_axi_araddr), 64'h1234_5678_9AB8);
        checkOutput("t1_arlen", 64'(bus.m_axi_arlen), 64'd0);
        checkOutput("t1_arsize", 64'(bus.m_axi_arsize), 64'd3);
        checkOutput("t1_arburst", 64'(bus.m_axi_arburst), 64'd1);
        checkOutput("t1_arid", 64'(bus.m_axi_arid), 64'd0);
        checkOutput("t1_outstanding1", 64'(outstanding), 64'd1);
        cycle();
        checkOutput("t1_arvalid_clr", 64'(bus.m_axi_arvalid), 64'd0);
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = 64'hDEAD_BEEF_0000_0001;
        #1;
        checkOutput("t1_resp_tvalid", 64'(bus.resp_tvalid), 64'd1);
        checkOutput("t1_rready", 64'(bus.m_axi_rready), 64'd1);
        checkOutput("t1_resp_tag", 64'(bus.resp_tag), 64'h00A5);
        checkOutput("t1_resp_data", 64'(bus.resp_data), 64'hDEAD_BEEF_0000_0001);
        checkOutput("t1_resp_err", 64'(bus.resp_err), 64'd0);
        cycle();
        bus.m_axi_rvalid = 1'b0;
        checkOutput("t1_outstanding0", 64'(outstanding), 64'd0);

        // ---------------- 2: AR backpressure ----------------
        $display("[TB] test 2: AR backpressure");
        bus.m_axi_arready = 1'b0;
        acceptCount = 0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b1, 48'h1000 + 48'(8 * idx), 16'(16'h10 + idx));
            cycle();
            if (sawAccept) idx++;
            checkOutput("t2_arvalid_hold", 64'(bus.m_axi_arvalid), 64'd1);
            checkOutput("t2_araddr_hold", 64'(bus.m_axi_araddr), 64'h1000);
        end
        checkOutput("t2_accepts_blocked", 64'(acceptCount), 64'd1);
        arQ.delete();
        arCount = 0;
        bus.m_axi_arready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (idx < 8) applyStimulus(1'b1, 48'h1000 + 48'(8 * idx), 16'(16'h10 + idx));
            else         applyStimulus(1'b0, '0, '0);
            cycle();
            if (sawAccept) idx++;
        end
        applyStimulus(1'b0, '0, '0);
        checkOutput("t2_ar_count", 64'(arCount), 64'd8);
        for (int i = 0; i < 8 && i < arQ.size(); i++) begin
            checkOutput("t2_ar_addr", 64'(arQ[i]), 64'h1000 + 64'(8 * i));
        end
        checkOutput("t2_accepts", 64'(acceptCount), 64'd8);
        checkOutput("t2_outstanding", 64'(outstanding), 64'd8);
        drain("t2", 16'h0010, 8);
        checkOutput("t2_outstanding0", 64'(outstanding), 64'd0);

        // ---------------- 3: full limit ----------------
        $display("[TB] test 3: outstanding limit");
        bus.m_axi_arready = 1'b1;
        acceptCount = 0;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b1, 48'h3000 + 48'(8 * idx), 16'(16'h20 + idx));
            cycle();
            if (sawAccept) idx++;
        end
        checkOutput("t3_accepts", 64'(acceptCount), 64'd8);
        checkOutput("t3_outstanding", 64'(outstanding), 64'd8);
        checkOutput("t3_req_tready_full", 64'(bus.req_tready), 64'd0);
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = 64'h3333;
        #1;
        checkOutput("t3_first_tag", 64'(bus.resp_tag), 64'h0020);
        checkOutput("t3_tready_during_deliver", 64'(bus.req_tready), 64'd0);
        cycle();
        if (sawAccept) idx++;
        bus.m_axi_rvalid = 1'b0;
        #1;
        checkOutput("t3_no_accept_same_cycle", 64'(acceptCount), 64'd8);
        checkOutput("t3_outstanding7", 64'(outstanding), 64'd7);
        checkOutput("t3_req_tready_reopen", 64'(bus.req_tready), 64'd1);
        cycle();
        if (sawAccept) idx++;
        applyStimulus(1'b0, '0, '0);
        checkOutput("t3_one_more_accept", 64'(acceptCount), 64'd9);
        checkOutput("t3_outstanding_refull", 64'(outstanding), 64'd8);
        cycle();
        drain("t3", 16'h0021, 8);
        checkOutput("t3_outstanding0", 64'(outstanding), 64'd0);

        // ---------------- 4: streaming with random backpressure ----------------
        $display("[TB] test 4: streaming 20 tags");
        arQ.delete();
        respTags.delete();
        respData.delete();
        autoResp = 1'b1;
        idx = 0;
        for (int c = 0; c < 400 && respTags.size() < 20; c++) begin
            bus.m_axi_arready = 1'($urandom_range(0, 1));
            bus.resp_tready   = 1'($urandom_range(0, 1));
            if (idx < 20) applyStimulus(1'b1, 48'h4000_0000 + 48'(8 * idx) + 48'd3, 16'(idx));
            else          applyStimulus(1'b0, '0, '0);
            cycle();
            if (sawAccept) idx++;
        end
        autoResp = 1'b0;
        applyStimulus(1'b0, '0, '0);
        bus.m_axi_rvalid  = 1'b0;
        bus.resp_tready   = 1'b1;
        bus.m_axi_arready = 1'b1;
        checkOutput("t4_resp_count", 64'(respTags.size()), 64'd20);
        for (int i = 0; i < 20 && i < respTags.size(); i++) begin
            checkOutput("t4_tag", 64'(respTags[i]), 64'(i));
            checkOutput("t4_data", 64'(respData[i]), {16'hC0DE, 48'h4000_0000 + 48'(8 * i)});
        end
        checkOutput("t4_outstanding0", 64'(outstanding), 64'd0);

        // ---------------- 5: simultaneous accept and delivery ----------------
        $display("[TB] test 5: accept and delivery together");
        acceptCount = 0;
        idx = 0;
        for (int c = 0; c < 10 && idx < 5; c++) begin
            applyStimulus(1'b1, 48'h5000 + 48'(8 * idx), 16'(16'h50 + idx));
            cycle();
            if (sawAccept) idx++;
        end
        applyStimulus(1'b0, '0, '0);
        cycle();
        checkOutput("t5_outstanding5", 64'(outstanding), 64'd5);
        applyStimulus(1'b1, 48'h5028, 16'h0055);
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = 64'h5555;
        #1;
        checkOutput("t5_req_tready", 64'(bus.req_tready), 64'd1);
        checkOutput("t5_head_tag", 64'(bus.resp_tag), 64'h0050);
        cycle();
        checkOutput("t5_both_handshakes", 64'({sawAccept, sawDelivery}), 64'b11);
        applyStimulus(1'b0, '0, '0);
        bus.m_axi_rvalid = 1'b0;
        #1;
        checkOutput("t5_outstanding_same", 64'(outstanding), 64'd5);
        drain("t5", 16'h0051, 5);
        checkOutput("t5_outstanding0", 64'(outstanding), 64'd0);

        // ---------------- 6: unexpected R beat and reset mid-burst ----------------
        $display("[TB] test 6: unexpected R and mid-burst reset");
        bus.m_axi_rvalid = 1'b1;
        bus.resp_tready  = 1'b0;
        #1;
        checkOutput("t6_rready_drop", 64'(bus.m_axi_rready), 64'd1);
        checkOutput("t6_resp_tvalid_drop", 64'(bus.resp_tvalid), 64'd0);
        cycle();
        bus.m_axi_rvalid = 1'b0;
        bus.resp_tready  = 1'b1;
        checkOutput("t6_err_set", 64'(errUnexpectedR), 64'd1);
        checkOutput("t6_outstanding_zero", 64'(outstanding), 64'd0);
        repeat (3) cycle();
        checkOutput("t6_err_sticky", 64'(errUnexpectedR), 64'd1);
        bus.m_axi_arready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 48'h6000 + 48'(8 * i), 16'(16'h60 + i));
            cycle();
        end
        applyStimulus(1'b0, '0, '0);
        bus.m_axi_arready = 1'b0;
        #1;
        checkOutput("t6_outstanding3", 64'(outstanding), 64'd3);
        checkOutput("t6_arvalid_busy", 64'(bus.m_axi_arvalid), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
        checkOutput("t6_rst_outstanding", 64'(outstanding), 64'd0);
        checkOutput("t6_rst_err", 64'(errUnexpectedR), 64'd0);
        checkOutput("t6_rst_req_tready", 64'(bus.req_tready), 64'd0);
        repeat (2) cycle();
        rst = 1'b0;
        #1;
        checkOutput("t6_post_rst_tready", 64'(bus.req_tready), 64'd1);
        bus.m_axi_arready = 1'b1;
        applyStimulus(1'b1, 48'h2000, 16'h0066);
        cycle();
        applyStimulus(1'b0, '0, '0);
        cycle();
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = 64'h6666;
        #1;
        checkOutput("t6_post_rst_tvalid", 64'(bus.resp_tvalid), 64'd1);
        checkOutput("t6_post_rst_tag", 64'(bus.resp_tag), 64'h0066);
        cycle();
        bus.m_axi_rvalid = 1'b0;
        checkOutput("t6_post_rst_outstanding", 64'(outstanding), 64'd0);
        checkOutput("t6_post_rst_err", 64'(errUnexpectedR), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
